// File: rtl/sram_pkg.sv
// Shared SRAM map constants and pixel-fetch types.
package sram_pkg;

  localparam int SRAM_ADDR_COUNT   = 20;
  localparam int SRAM_DATA_WIDTH   = 16;
  localparam int PIXEL_WIDTH_WIDTH = 4;
  localparam int PIXELS_PER_ADDR   = 4;
  localparam int REQ_WORDS_WIDTH   = 19;

  localparam logic [SRAM_ADDR_COUNT-1:0] PLAYER1_ADDR_START = 20'h4E200;
  localparam int                         PLAYER1_ADDR_COUNT = 400;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_RUN,
    FETCH_DRAIN,
    FETCH_FLUSH
  } fetch_state_t;

  // Index 0 selects the most significant nibble.
  function automatic logic [PIXEL_WIDTH_WIDTH-1:0] pixel_select(
    input logic [SRAM_DATA_WIDTH-1:0] word,
    input logic [1:0]                 idx
  );
    logic [SRAM_DATA_WIDTH-1:0] shifted;
    shifted = word << {idx, 2'b00};
    return shifted[SRAM_DATA_WIDTH-1 -: PIXEL_WIDTH_WIDTH];
  endfunction

endpackage

// File: rtl/sram_word_fifo.sv
// Small synchronous word FIFO with occupancy count and synchronous clear.
module sram_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  // The caller's credit check must keep these from ever firing.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (push && !clear) |-> (pop || (count < CNT_W'(DEPTH))));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    (pop && !clear) |-> !empty);

endmodule

// File: rtl/sram_pixel_fetch.sv
// Streams a run of SRAM words out as 4-bit pixels, MSB nibble first.
// Define SRAM_FETCH_ABORT_EN to add the i_abort input and the FLUSH state.
module sram_pixel_fetch
  import sram_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SRAM_LAT   = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  logic [SRAM_ADDR_COUNT-1:0]   i_req_base,
  input  logic [REQ_WORDS_WIDTH-1:0]   i_req_words,
  output logic                         o_sram_rd,
  output logic [SRAM_ADDR_COUNT-1:0]   o_sram_addr,
  input  logic [SRAM_DATA_WIDTH-1:0]   i_sram_dq,
  output logic                         o_pix_valid,
  input  logic                         i_pix_ready,
  output logic [PIXEL_WIDTH_WIDTH-1:0] o_pix,
  output logic                         o_pix_last,
  output logic                         o_busy
`ifdef SRAM_FETCH_ABORT_EN
  ,
  input  logic                         i_abort
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [1:0] LAST_IDX = 2'(PIXELS_PER_ADDR - 1);

  fetch_state_t                 state_q, state_d;
  logic [SRAM_ADDR_COUNT-1:0]   addr_q;
  logic [REQ_WORDS_WIDTH-1:0]   remain_q;
  logic [REQ_WORDS_WIDTH-1:0]   words_left_q;
  logic [CNT_W-1:0]             outstanding_q;
  logic [CNT_W-1:0]             fifo_count;
  logic [SRAM_LAT-1:0]          inflight_q;
  logic                         zero_req_q;
  logic [SRAM_DATA_WIDTH-1:0]   word_q;
  logic [SRAM_DATA_WIDTH-1:0]   fifo_dout;
  logic                         word_valid_q;
  logic                         word_last_q;
  logic [1:0]                   idx_q;
  logic                         fifo_empty;
  logic                         fifo_push, fifo_pop;
  logic                         req_fire, pix_fire, ret, keep_ret, take_word;
  logic                         credit, abort_now;

`ifdef SRAM_FETCH_ABORT_EN
  assign abort_now = i_abort && (state_q == FETCH_RUN || state_q == FETCH_DRAIN);
`else
  assign abort_now = 1'b0;
`endif

  // Words in the FIFO plus reads still in flight must fit in the FIFO.
  assign credit = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < (CNT_W + 1)'(FIFO_DEPTH);

  assign o_req_ready = (state_q == FETCH_IDLE) && !zero_req_q;
  assign o_busy      = (state_q != FETCH_IDLE);
  assign o_sram_rd   = (state_q == FETCH_RUN) && credit && !abort_now;
  assign o_sram_addr = addr_q;
  assign o_pix_valid = word_valid_q;
  assign o_pix       = pixel_select(word_q, idx_q);
  assign o_pix_last  = word_valid_q && word_last_q && (idx_q == LAST_IDX);

  assign req_fire  = i_req_valid && o_req_ready;
  assign pix_fire  = word_valid_q && i_pix_ready;
  assign ret       = inflight_q[SRAM_LAT-1];
  assign keep_ret  = ret && (state_q != FETCH_FLUSH) && !abort_now;
  assign take_word = !word_valid_q || (pix_fire && idx_q == LAST_IDX);
  assign fifo_pop  = take_word && !fifo_empty && !abort_now;
  // A returning word bypasses an empty FIFO straight into the unpacker.
  assign fifo_push = keep_ret && !(take_word && fifo_empty);

  sram_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SRAM_DATA_WIDTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .clear (abort_now),
    .push  (fifo_push),
    .din   (i_sram_dq),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_IDLE:  if (req_fire && i_req_words != '0) state_d = FETCH_RUN;
      FETCH_RUN: begin
        if (abort_now) state_d = FETCH_FLUSH;
        else if (o_sram_rd && remain_q == REQ_WORDS_WIDTH'(1)) state_d = FETCH_DRAIN;
      end
      FETCH_DRAIN: begin
        if (abort_now) state_d = FETCH_FLUSH;
        else if (pix_fire && o_pix_last) state_d = FETCH_IDLE;
      end
`ifdef SRAM_FETCH_ABORT_EN
      FETCH_FLUSH: if (outstanding_q == '0) state_d = FETCH_IDLE;
`endif
      default:     state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= FETCH_IDLE;
      addr_q        <= '0;
      remain_q      <= '0;
      words_left_q  <= '0;
      outstanding_q <= '0;
      inflight_q    <= '0;
      zero_req_q    <= 1'b0;
      word_q        <= '0;
      word_valid_q  <= 1'b0;
      word_last_q   <= 1'b0;
      idx_q         <= '0;
    end else begin
      state_q       <= state_d;
      zero_req_q    <= req_fire && (i_req_words == '0);
      inflight_q    <= SRAM_LAT'({inflight_q, o_sram_rd});
      outstanding_q <= outstanding_q + CNT_W'(o_sram_rd) - CNT_W'(ret);

      if (req_fire) begin
        addr_q       <= i_req_base;
        remain_q     <= i_req_words;
        words_left_q <= i_req_words;
      end else if (o_sram_rd) begin
        addr_q   <= addr_q + 1'b1;
        remain_q <= remain_q - 1'b1;
      end

      if (abort_now) begin
        word_valid_q <= 1'b0;
        word_last_q  <= 1'b0;
        idx_q        <= '0;
      end else if (take_word) begin
        idx_q <= '0;
        if (!fifo_empty || keep_ret) begin
          word_q       <= fifo_empty ? i_sram_dq : fifo_dout;
          word_valid_q <= 1'b1;
          word_last_q  <= (words_left_q == REQ_WORDS_WIDTH'(1));
          words_left_q <= words_left_q - 1'b1;
        end else begin
          word_valid_q <= 1'b0;
        end
      end else if (pix_fire) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_pixel_fetch.sv
// Scoreboard bench for sram_pixel_fetch: stimulus queues expected reads and pixels,
// monitors pop and compare. The abort test is built only with SRAM_FETCH_ABORT_EN.
module tb_sram_pixel_fetch;
  import sram_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [19:0] i_req_base = '0;
  logic [18:0] i_req_words = '0;
  logic        o_sram_rd;
  logic [19:0] o_sram_addr;
  logic [15:0] i_sram_dq = 16'hDEAD;
  logic        o_pix_valid;
  logic        i_pix_ready = 1'b1;
  logic [3:0]  o_pix;
  logic        o_pix_last;
  logic        o_busy;
`ifdef SRAM_FETCH_ABORT_EN
  logic        i_abort = 1'b0;
`endif

  int          nVec = 0;
  int          nMis = 0;
  int          pixSeen = 0;
  int          readyMode = 0;
  logic        prevStall = 1'b0;
  logic [4:0]  prevPix = '0;
  logic [4:0]  pixQ[$];
  logic [19:0] addrQ[$];

  sram_pixel_fetch #(.FIFO_DEPTH(4), .SRAM_LAT(1)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_base  (i_req_base),
    .i_req_words (i_req_words),
    .o_sram_rd   (o_sram_rd),
    .o_sram_addr (o_sram_addr),
    .i_sram_dq   (i_sram_dq),
    .o_pix_valid (o_pix_valid),
    .i_pix_ready (i_pix_ready),
    .o_pix       (o_pix),
    .o_pix_last  (o_pix_last),
    .o_busy      (o_busy)
`ifdef SRAM_FETCH_ABORT_EN
    ,
    .i_abort     (i_abort)
`endif
  );

  always #5 i_clk = ~i_clk;

  // SRAM contents: address 0 holds 0xA5C3.
  function automatic logic [15:0] memWord(input logic [19:0] a);
    return a[15:0] ^ {a[19:16], 12'h000} ^ 16'hA5C3;
  endfunction

  // One-cycle-latency SRAM; junk when no read was issued.
  always @(posedge i_clk) i_sram_dq <= o_sram_rd ? memWord(o_sram_addr) : 16'hDEAD;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVec++;
    if (actual !== expected) begin
      nMis++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [19:0] base, input int words);
    logic [19:0] a;
    logic [15:0] w;
    for (int i = 0; i < words; i++) begin
      a = base + 20'(i);
      w = memWord(a);
      addrQ.push_back(a);
      for (int k = 0; k < 4; k++)
        pixQ.push_back({(i == words - 1) && (k == 3), w[(15 - 4 * k) -: 4]});
    end
    i_req_base  = base;
    i_req_words = 19'(words);
    i_req_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget);
    int n = 0;
    while ((pixQ.size() != 0 || addrQ.size() != 0 || !o_req_ready) && n < budget) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    checkOutput(name, 32'(n < budget), 32'd1);
  endtask

  task automatic waitPixel(input int target);
    int n = 0;
    while (pixSeen < target && n < 2000) begin
      @(posedge i_clk);
      n++;
    end
    checkOutput("reach_pix37", 32'(pixSeen >= target), 32'd1);
    #1;
  endtask

  task automatic checkResetValues(input string name);
    checkOutput(name, {o_req_ready, o_sram_rd, o_pix_valid, o_pix_last, o_busy, o_pix, o_sram_addr},
                {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 20'h00000});
  endtask

  // Ready driver: always high, or a coin flip each cycle.
  initial forever begin
    @(posedge i_clk);
    #1;
    i_pix_ready = (readyMode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops expectations on every read strobe and pixel handshake.
  initial forever begin
    @(negedge i_clk);
    if (!i_rst) begin
      if (prevStall) checkOutput("stall_hold", {o_pix_valid, o_pix_last, o_pix}, {1'b1, prevPix});
      if (o_pix_valid && i_pix_ready) begin
        checkOutput("pixel", {1'b0, o_pix_last, o_pix},
                    (pixQ.size() > 0) ? {1'b0, pixQ.pop_front()} : 6'h20);
        pixSeen++;
      end
      if (o_sram_rd)
        checkOutput("rd_addr", {1'b0, o_sram_addr},
                    (addrQ.size() > 0) ? {1'b0, addrQ.pop_front()} : 21'h100000);
      prevStall = o_pix_valid && !i_pix_ready;
      prevPix   = {o_pix_last, o_pix};
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int start;
    repeat (3) @(posedge i_clk);
    #1;
    checkResetValues("reset_values");
    i_rst = 1'b0;

    // Single word 0xA5C3: first read at T+1, first pixel at T+3.
    applyStimulus(20'h00000, 1);
    checkOutput("first_rd_T1", {31'd0, o_sram_rd}, 32'd1);
    lat = 0;
    while (!o_pix_valid && lat < 10) begin
      @(posedge i_clk);
      lat++;
      @(negedge i_clk);
    end
    checkOutput("first_valid_T3", 32'(lat), 32'd2);
    checkOutput("first_pix_A", {28'd0, o_pix}, 32'hA);
    waitDone("done_one_word", 50);

    // Zero-word request: ready low exactly one cycle, nothing issued.
    applyStimulus(20'h12345, 0);
    checkOutput("zero_ready_low", {o_req_ready, o_busy}, 2'b00);
    @(posedge i_clk);
    #1;
    checkOutput("zero_ready_back", {o_req_ready, o_busy}, 2'b10);
    repeat (4) @(posedge i_clk);
    #1;

    // Address wrap across 0xFFFFF.
    applyStimulus(20'hFFFFE, 4);
    waitDone("done_wrap", 100);

    // Player1 sprite with the sink always ready, then back-to-back request.
    start = pixSeen;
    applyStimulus(PLAYER1_ADDR_START, PLAYER1_ADDR_COUNT);
    waitDone("done_player1", 3000);
    checkOutput("player1_pix_count", 32'(pixSeen - start), 32'd1600);
    applyStimulus(20'h00100, 2);
    waitDone("done_back_to_back", 100);

    // Random backpressure over 100 words.
    readyMode = 1;
    applyStimulus(20'h21000, 100);
    waitDone("done_random", 3000);
    readyMode = 0;
    @(posedge i_clk);
    #1;

    // Reset at pixel 37 of a 400-word request, then a fresh request.
    start = pixSeen;
    applyStimulus(PLAYER1_ADDR_START, PLAYER1_ADDR_COUNT);
    waitPixel(start + 37);
    i_rst = 1'b1;
    #1;
    checkResetValues("async_reset_values");
    pixQ.delete();
    addrQ.delete();
    prevStall = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    applyStimulus(20'h01000, 8);
    waitDone("done_after_reset", 200);

`ifdef SRAM_FETCH_ABORT_EN
    // Abort at pixel 37: valid drops next cycle, no last, returns to IDLE.
    start = pixSeen;
    applyStimulus(PLAYER1_ADDR_START, PLAYER1_ADDR_COUNT);
    waitPixel(start + 37);
    i_abort = 1'b1;
    @(posedge i_clk);
    #1;
    i_abort = 1'b0;
    prevStall = 1'b0;
    pixQ.delete();
    addrQ.delete();
    checkOutput("abort_valid_low", {o_pix_valid, o_pix_last, o_sram_rd}, 3'b000);
    waitDone("abort_idle", 20);
    applyStimulus(20'h02000, 3);
    waitDone("done_after_abort", 100);
`endif

    repeat (5) @(posedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/sram_pixel_fetch.md
# sram_pixel_fetch

Reads a contiguous run of 16-bit SRAM words holding packed 4-bit pixels and unpacks each word into a stream of 4 pixels for the VGA compositor. It sits between the SRAM controller and the display pipeline. It serves any image region defined in `sram_pkg`: map, player/shield/squat sprites, bullets, captions and backgrounds. Requests carry a region base address and word count. Backpressure from the pixel sink is absorbed by a small word FIFO, so SRAM reads are issued only when there is space.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: word FIFO entries; power of two, at least 2.
- `SRAM_LAT`, default 1: fixed cycles from `o_sram_rd` to valid `i_sram_dq`.

Ports:
- `i_clk` in 1: single clock.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_req_valid` in 1: fetch request valid.
- `o_req_ready` out 1: block can accept a request; high only in IDLE.
- `i_req_base` in 20: first SRAM word address.
- `i_req_words` in 19: word count; the largest region is 360000 words.
- `o_sram_rd` out 1: read strobe for one word.
- `o_sram_addr` out 20: read address.
- `i_sram_dq` in 16: read data, valid `SRAM_LAT` cycles after `o_sram_rd`.
- `o_pix_valid` out 1: pixel valid.
- `i_pix_ready` in 1: sink accepts pixel.
- `o_pix` out 4: pixel colour index.
- `o_pix_last` out 1: final pixel of the request.
- `o_busy` out 1: state is not IDLE.
- `i_abort` in 1: present only with `SRAM_FETCH_ABORT_EN`.

## Operation
- FSM states:
  - IDLE: request accepted on `i_req_valid & o_req_ready`; base and count are latched.
  - RUN: reads are issued.
  - DRAIN: all reads issued; waits until the FIFO is empty, outstanding reads are zero and the final pixel is accepted, then returns to IDLE.
- A request with `i_req_words == 0` goes IDLE to IDLE with no reads and no pixels. `o_req_ready` drops for one cycle.
- Read issue in RUN: assert `o_sram_rd` when `fifo_count + outstanding < FIFO_DEPTH`.
  - `o_sram_addr` increments by 1 per issued read.
  - Remaining count decrements per issued read; RUN goes to DRAIN on the cycle the last read issues.
- Address arithmetic is 20-bit and wraps from 0xFFFFF to 0x00000 with no error.
- Returned words are pushed into the FIFO `SRAM_LAT` cycles after the read. A shift register of length `SRAM_LAT` tracks in-flight reads.
- The FIFO can never overflow; the credit check guarantees this. An overflow is an assertion failure.
- Unpacker: pops a word, then emits 4 pixels, MSB nibble first: [15:12], [11:8], [7:4], [3:0].
  - The pixel index advances only on `o_pix_valid & i_pix_ready`.
  - The next word pops on the same cycle the 4th nibble is accepted, so there is no bubble.
- `o_pix_last` is high with the nibble [3:0] of the last word of the request.
- `o_pix`, `o_pix_valid` and `o_pix_last` hold stable while `o_pix_valid & ~i_pix_ready`.

## Timing
- Reset values: `o_req_ready=1`, `o_sram_rd=0`, `o_sram_addr=0`, `o_pix_valid=0`, `o_pix=0`, `o_pix_last=0`, `o_busy=0`. FIFO is emptied, counters are zero, state is IDLE.
- Reset asserted mid-transfer discards all in-flight data. Late-returning `i_sram_dq` is ignored.
- Request accepted at cycle T gives first `o_sram_rd` at T+1.
- With `SRAM_LAT=1`, the first word is captured at T+2 and the first `o_pix_valid` is registered at T+3.
- Sustained throughput with `i_pix_ready` held high: 4 pixels per word. The read rate self-throttles to about 1 read per 4 cycles once the FIFO fills.
- `o_req_ready` returns high the cycle after the last pixel handshake.
- A new request can then be accepted that cycle, making back-to-back requests 1 idle cycle apart.

## Configuration
- `SRAM_FETCH_ABORT_EN` defined: adds `i_abort`. When sampled high in RUN or DRAIN:
  - issuing stops immediately;
  - the FIFO and unpacker are cleared and `o_pix_valid` drops the next cycle;
  - the FSM moves to a FLUSH state until outstanding reads return and are discarded, then goes to IDLE;
  - `o_pix_last` is not emitted for an aborted request;
  - `i_abort` is ignored in IDLE.
- Not defined: no `i_abort` port and no FLUSH state; a request always runs to completion.

## Structure
- Add to `sram_pkg`:
  - `SRAM_ADDR_COUNT` (20) for the `o_sram_addr` width;
  - `PIXEL_WIDTH_WIDTH` (4) and `PIXELS_PER_ADDR` (4) for the unpacker;
  - a `localparam int REQ_WORDS_WIDTH = 19`;
  - a `typedef enum logic [1:0] {FETCH_IDLE, FETCH_RUN, FETCH_DRAIN, FETCH_FLUSH}`.
- Region bases are taken from the existing package `*_ADDR_START` / `*_ADDR_COUNT` constants by the caller.
- One sub-module, `sram_word_fifo`: synchronous FIFO, `FIFO_DEPTH` x 16, with push/pop/count/empty, asynchronous active-high reset.

## Test plan
- Player1 sprite request, base 0x4E200, 400 words, `i_pix_ready` held 1 -> exactly 1600 pixels, nibble order [15:12] first, `o_pix_last` only on pixel 1600, 400 reads at addresses 0x4E200..0x4E38F.
- Word 0xA5C3 at base 0x00000, 1 word -> pixels A, 5, C, 3; `o_pix_last` with 3; first valid at T+3.
- Random `i_pix_ready` (50%) over 100 words -> no lost or duplicated pixel, outputs stable while stalled, FIFO count never exceeds 4, outstanding never exceeds `FIFO_DEPTH`.
- Zero-word request -> no `o_sram_rd`, no `o_pix_valid`, `o_req_ready` low for 1 cycle.
- Base 0xFFFFE, 4 words -> addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
- `i_rst` pulsed at pixel 37 of a 400-word request -> all outputs reach reset values asynchronously. A fresh request afterwards streams correctly. With `SRAM_FETCH_ABORT_EN`, `i_abort` at pixel 37 -> `o_pix_valid` low next cycle, no `o_pix_last`, `o_req_ready` high after outstanding reads drain.
